flexbyte_tx_ctrl: RTL and testbench

Sequencing controller for the multibyte parallel-to-serial shift register: it accepts whole words from an upstream producer over a valid/ready handshake and drives the shift register's `load_enable`/`shift_enable` strobes. It presents each shifted-out chunk to the downstream byte consumer over a second valid/ready handshake, with chunk index and last-chunk flags. It sits between the word source and the byte sink, alongside the shift register that holds the data. It does not hold the data itself.

---
 rtl/flexbyte_pkg.sv | 15 +
 rtl/flexbyte_stall_cnt.sv | 27 ++
 rtl/flexbyte_tx_ctrl.sv | 125 ++++++++++++
 tb/tb_flexbyte_tx_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flexbyte_pkg.sv
// Shared types and helpers for the flexbyte transmit sequencing controller.
package flexbyte_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of output chunks per input word; 0 flags an unusable chunk width.
  function automatic int unsigned chunk_count(input int unsigned n_in,
                                              input int unsigned n_out);
    return (n_out == 0) ? 0 : n_in / n_out;
  endfunction

endpackage

// File: rtl/flexbyte_stall_cnt.sv
// Saturating count of consecutive stalled cycles; flags the cycle whose stall reaches LIMIT.
module flexbyte_stall_cnt #(
  parameter  int unsigned LIMIT = 255,
  localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_stall,
  output logic o_reach_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_stall && (r_cnt != CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_reach_c = i_stall & (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/flexbyte_tx_ctrl.sv
// Word-to-chunk sequencing controller driving an external shift register's load/shift strobes.
// Optional stall timeout compiled in with FLEXBYTE_TX_CTRL_TIMEOUT_EN.
module flexbyte_tx_ctrl
  import flexbyte_pkg::*;
#(
  parameter  int unsigned NUM_BYTES_IN   = 2,
  parameter  int unsigned NUM_BYTES_OUT  = 1,
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CHUNKS         = chunk_count(NUM_BYTES_IN, NUM_BYTES_OUT),
  localparam int unsigned IDX_W          = ($clog2(CHUNKS) > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             load_enable,
  output logic             shift_enable,
  output logic             chunk_valid,
  input  logic             chunk_ready,
  output logic [IDX_W-1:0] chunk_idx,
  output logic             chunk_last,
  output logic             timeout_err
);

  if ((NUM_BYTES_OUT == 0) ||
      ((NUM_BYTES_IN % ((NUM_BYTES_OUT == 0) ? 1 : NUM_BYTES_OUT)) != 0)) begin : g_chk_div
    $fatal(1, "flexbyte_tx_ctrl: NUM_BYTES_IN must be a multiple of NUM_BYTES_OUT");
  end
  if (CHUNKS < 2) begin : g_chk_chunks
    $fatal(1, "flexbyte_tx_ctrl: at least two chunks per word are required");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_chk_timeout
    $fatal(1, "flexbyte_tx_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_last;
  logic             w_acc;
  logic             w_fin;
  logic             w_ready;
  logic             w_load;

  assign w_acc   = r_valid & chunk_ready;
  assign w_fin   = w_acc & r_last;
  assign w_ready = ~rst & ((r_state == IDLE) | w_fin);
  assign w_load  = word_valid & w_ready;

  // Sequencer: a finishing word hands over directly to the next load without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        SEND: begin
          if (w_fin) begin
            r_idx  <= '0;
            r_last <= 1'b0;
            if (!w_load) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end else if (w_acc) begin
            r_idx  <= r_idx + IDX_W'(1);
            r_last <= (r_idx == IDX_W'(CHUNKS - 2));
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready   = w_ready;
  assign load_enable  = w_load;
  assign shift_enable = w_acc & ~r_last;
  assign chunk_valid  = r_valid;
  assign chunk_idx    = r_idx;
  assign chunk_last   = r_last;

`ifdef FLEXBYTE_TX_CTRL_TIMEOUT_EN
  logic w_reach;
  logic r_timeout_err;

  flexbyte_stall_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stall_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (~r_valid | w_acc),
    .i_stall   (r_valid & ~chunk_ready),
    .o_reach_c (w_reach)
  );

  // Sticky until reset; data flow never looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_reach) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_flexbyte_tx_ctrl.sv
// Scoreboard bench for flexbyte_tx_ctrl (4-byte words, 1-byte chunks) with a behavioural shift register.
module tb_flexbyte_tx_ctrl;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       word_valid;
  logic       word_ready;
  logic       load_enable;
  logic       shift_enable;
  logic       chunk_valid;
  logic       chunk_ready;
  logic [1:0] chunk_idx;
  logic       chunk_last;
  logic       timeout_err;

  logic [31:0] word_data;
  logic [31:0] m_sr;

  typedef struct {
    logic [1:0] idx;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_ld    = 0;
  int n_sh    = 0;
  int run_len = 0;
  int max_run = 0;
  int n_wr_busy = 0;
  int m_stall = 0;
  logic m_err = 1'b0;

  flexbyte_tx_ctrl #(
    .NUM_BYTES_IN   (4),
    .NUM_BYTES_OUT  (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .load_enable  (load_enable),
    .shift_enable (shift_enable),
    .chunk_valid  (chunk_valid),
    .chunk_ready  (chunk_ready),
    .chunk_idx    (chunk_idx),
    .chunk_last   (chunk_last),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare against the scoreboard, then advance the reference model.
  always @(negedge clk) begin
    logic exp_wr;
    logic acc;
    if (rst) begin
      chk("rst_cv", 32'(chunk_valid), 32'd0);
      chk("rst_wr", 32'(word_ready), 32'd0);
      chk("rst_ld", 32'(load_enable), 32'd0);
      chk("rst_sh", 32'(shift_enable), 32'd0);
      run_len = 0;
    end else begin
      acc    = chunk_valid & chunk_ready;
      exp_wr = (q.size() == 0) || ((q.size() == 1) && chunk_ready);
      chk("cv", 32'(chunk_valid), 32'(q.size() != 0));
      if (chunk_valid && q.size() != 0) begin
        chk("idx", 32'(chunk_idx), 32'(q[0].idx));
        chk("last", 32'(chunk_last), 32'(q[0].last));
        chk("byte", 32'(m_sr[7:0]), 32'(q[0].data));
      end
      chk("wr", 32'(word_ready), 32'(exp_wr));
      chk("ld", 32'(load_enable), 32'(word_valid & exp_wr));
      chk("sh", 32'(shift_enable), 32'(acc && (q.size() > 1)));
      chk("terr", 32'(timeout_err), 32'(m_err));

      if (load_enable) n_ld++;
      if (shift_enable) n_sh++;
      if (chunk_valid && word_ready) n_wr_busy++;
      run_len = chunk_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;

`ifdef FLEXBYTE_TX_CTRL_TIMEOUT_EN
      if (chunk_valid && !chunk_ready) begin
        if (m_stall < int'(TO)) m_stall++;
        if (m_stall == int'(TO)) m_err = 1'b1;
      end else begin
        m_stall = 0;
      end
`endif

      if (acc && q.size() != 0) void'(q.pop_front());
      if (load_enable) begin
        for (int i = 0; i < 4; i++) begin
          exp_t e;
          e.idx  = 2'(i);
          e.last = (i == 3);
          e.data = word_data[8*i +: 8];
          q.push_back(e);
        end
        m_sr = word_data;
      end else if (shift_enable) begin
        m_sr = m_sr >> 8;
      end
    end
  end

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    q.delete();
    m_stall = 0;
    m_err   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for the load handshake, returning one step after the edge that takes the word.
  task automatic wait_load();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_enable && n < 50);
    chk("load_seen", 32'(load_enable), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] d);
    word_data  = d;
    word_valid = 1'b1;
    wait_load();
    word_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int ld0;
    int sh0;
    word_valid  = 1'b0;
    word_data   = '0;
    chunk_ready = 1'b0;
    m_sr        = '0;

    // Reset held three cycles
    apply_reset(3);
    @(negedge clk);
    chk("rel_cv", 32'(chunk_valid), 32'd0);
    chk("rel_wr", 32'(word_ready), 32'd1);
    chk("rel_idx", 32'(chunk_idx), 32'd0);
    chk("rel_strobes", 32'({load_enable, shift_enable}), 32'd0);
    chk("rel_terr", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;

    // Single word, downstream always ready
    chunk_ready = 1'b1;
    ld0 = n_ld;
    sh0 = n_sh;
    drive_word(32'hA55A_C33C);
    chk("single_first_idx", 32'(chunk_idx), 32'd0);
    chk("single_first_cv", 32'(chunk_valid), 32'd1);
    drain();
    chk("single_loads", 32'(n_ld - ld0), 32'd1);
    chk("single_shifts", 32'(n_sh - sh0), 32'd3);
    @(negedge clk);
    chk("single_idle_cv", 32'(chunk_valid), 32'd0);
    @(posedge clk);
    #1;

    // Three back-to-back words with word_valid held
    max_run   = 0;
    n_wr_busy = 0;
    word_valid = 1'b1;
    word_data  = 32'h0302_0100;
    wait_load();
    word_data  = 32'h1312_1110;
    wait_load();
    word_data  = 32'h2322_2120;
    wait_load();
    word_valid = 1'b0;
    drain();
    chk("b2b_run", 32'(max_run), 32'd12);
    chk("b2b_wr_busy", 32'(n_wr_busy), 32'd3);

    // Backpressure at chunk 1 with a pending upstream word
    drive_word(32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chunk_ready = 1'b0;
    word_data   = 32'hCAFE_F00D;
    word_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_idx", 32'(chunk_idx), 32'd1);
      chk("bp_sh", 32'(shift_enable), 32'd0);
      chk("bp_wr", 32'(word_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chunk_ready = 1'b1;
    wait_load();
    word_valid = 1'b0;
    drain();

    // Reset in the middle of a word
    drive_word(32'h7654_3210);
    @(posedge clk);
    #1;
    chk("mid_idx", 32'(chunk_idx), 32'd1);
    rst = 1'b1;
    q.delete();
    m_stall = 0;
    m_err   = 1'b0;
    #1;
    chk("mid_async_cv", 32'(chunk_valid), 32'd0);
    chk("mid_async_idx", 32'(chunk_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_word(32'h89AB_CDEF);
    chk("mid_restart_idx", 32'(chunk_idx), 32'd0);
    drain();

`ifdef FLEXBYTE_TX_CTRL_TIMEOUT_EN
    // Seven stalls, an accept, then eight stalls
    drive_word(32'h5566_7788);
    chunk_ready = 1'b0;
    repeat (7) @(negedge clk);
    chk("to_after7", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    chunk_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chunk_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("to_during8", 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    chk("to_set", 32'(timeout_err), 32'd1);
    @(posedge clk);
    #1;
    chunk_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("to_sticky", 32'(timeout_err), 32'd1);
    apply_reset(2);
    chk("to_cleared", 32'(timeout_err), 32'd0);
`else
    // Long stall with the timeout compiled out
    drive_word(32'h5566_7788);
    chunk_ready = 1'b0;
    repeat (12) @(negedge clk);
    chk("to_absent", 32'(timeout_err), 32'd0);
    @(posedge clk);
    #1;
    chunk_ready = 1'b1;
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
